// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised inout RAM: FSM encoding,
// read-latency legality check and the even-parity helper.
package ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Widest data word the parity helper accepts.
    localparam int PAR_MAX_W = 256;

    function automatic bit rd_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Storage array with synchronous write and registered read.
// With RAM_PARITY_EN defined each word carries one extra even-parity bit.
module ram_sp_core
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wpar_inv_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rpar_o
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rword_q;
    logic [WORD_W-1:0] wword_s;

`ifdef RAM_PARITY_EN
    function automatic logic par_of(input logic [DATA_W-1:0] v);
        logic [PAR_MAX_W-1:0] ext;
        ext = '0;
        ext[DATA_W-1:0] = v;
        return even_parity(ext);
    endfunction

    assign wword_s = {par_of(wdata_i) ^ wpar_inv_i, wdata_i};
    assign rpar_o  = rword_q[DATA_W];
`else
    logic unused_par_inv_s;
    assign unused_par_inv_s = wpar_inv_i;
    assign wword_s = wdata_i;
    assign rpar_o  = 1'b0;
`endif

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wword_s;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rword_q <= '0;
        end else if (re_i) begin
            rword_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rword_q[DATA_W-1:0];

endmodule

// File: rtl/ram_inout_param.sv
// Single-port RAM on a bidirectional bus with post-reset clear, read latency
// 1 or 2, contention flag; parity checking is enabled with RAM_PARITY_EN.
module ram_inout_param
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr,
    input  logic [ADDR_W-1:0] add,
    inout  wire  [DATA_W-1:0] data,
    output logic              ready,
    output logic              rd_valid,
    output logic              err,
    input  logic              inj_par,
    output logic              par_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("ram_inout_param: RD_LAT must be 1 or 2");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              ready_q;
    logic              err_q, err_d;
    logic              v1_q;
    logic              we_s, re_s, winv_s, par_inj_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] core_rdata_s, out_data_s;
    logic              core_rpar_s, out_par_s;
    logic              drive_en_s;

`ifdef RAM_PARITY_EN
    assign par_inj_s = inj_par;
`else
    assign par_inj_s = 1'b0;
`endif

    // Next-state, clear-pointer, write/read and contention decode.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        err_d     = err_q;
        we_s      = 1'b0;
        waddr_s   = add;
        wdata_s   = data;
        winv_s    = 1'b0;
        re_s      = 1'b0;
        case (state_q)
            ST_INIT: begin
                we_s      = 1'b1;
                waddr_s   = clr_ptr_q;
                wdata_s   = {DATA_W{1'b0}};
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (cs && wr) begin
                    // A write landing while we own the bus is dropped and flagged.
                    if (drive_en_s) begin
                        err_d = 1'b1;
                    end else begin
                        we_s   = 1'b1;
                        winv_s = par_inj_s;
                    end
                end else if (cs) begin
                    re_s = 1'b1;
                end else begin
                    re_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM, clear pointer, status flags and first read-pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            v1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= (state_d == ST_IDLE);
            err_q     <= err_d;
            v1_q      <= re_s;
        end
    end

    ram_sp_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_s),
        .waddr_i   (waddr_s),
        .wdata_i   (wdata_s),
        .wpar_inv_i(winv_s),
        .re_i      (re_s),
        .raddr_i   (add),
        .rdata_o   (core_rdata_s),
        .rpar_o    (core_rpar_s)
    );

    if (RD_LAT == 2) begin : g_lat2
        logic              v2_q;
        logic [DATA_W-1:0] d2_q;
        logic              p2_q;

        // Extra output stage for two-cycle read latency.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2_q <= 1'b0;
                d2_q <= '0;
                p2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                d2_q <= core_rdata_s;
                p2_q <= core_rpar_s;
            end
        end

        assign drive_en_s = v2_q;
        assign out_data_s = d2_q;
        assign out_par_s  = p2_q;
    end else begin : g_lat1
        assign drive_en_s = v1_q;
        assign out_data_s = core_rdata_s;
        assign out_par_s  = core_rpar_s;
    end

    // drive_en comes straight from async-reset flops, so rst frees the bus at once.
    assign data     = drive_en_s ? out_data_s : {DATA_W{1'bz}};
    assign rd_valid = drive_en_s;
    assign ready    = ready_q;
    assign err      = err_q;

`ifdef RAM_PARITY_EN
    function automatic logic par_of(input logic [DATA_W-1:0] v);
        logic [PAR_MAX_W-1:0] ext;
        ext = '0;
        ext[DATA_W-1:0] = v;
        return even_parity(ext);
    endfunction

    assign par_err = drive_en_s & (par_of(out_data_s) ^ out_par_s);
`else
    logic unused_par_s;
    assign unused_par_s = out_par_s ^ inj_par;
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_inout_param.sv
// Directed bench for ram_inout_param: one instance with RD_LAT=1, a second
// with RD_LAT=2 (own chip select and data bus) for the latency check.
module tb_ram_inout_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs, cs2, wr, inj_par;
    logic [3:0] add;
    logic [7:0] tb_dout;
    logic       tb_den, tb_den2;
    wire  [7:0] data1, data2;
    logic       ready1, rd_valid1, err1, par_err1;
    logic       ready2, rd_valid2, err2, par_err2;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef RAM_PARITY_EN
    localparam logic EXP_INJ_PERR = 1'b1;
`else
    localparam logic EXP_INJ_PERR = 1'b0;
`endif

    assign data1 = tb_den  ? tb_dout : 8'hzz;
    assign data2 = tb_den2 ? tb_dout : 8'hzz;

    always #5 clk = ~clk;

    ram_inout_param #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .add(add), .data(data1),
        .ready(ready1), .rd_valid(rd_valid1), .err(err1),
        .inj_par(inj_par), .par_err(par_err1)
    );

    ram_inout_param #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .cs(cs2), .wr(wr), .add(add), .data(data2),
        .ready(ready2), .rd_valid(rd_valid2), .err(err2),
        .inj_par(inj_par), .par_err(par_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single read on dut1 with an idle cycle after it.
    task automatic read1(input logic [3:0] a, input logic [7:0] exp, input string nm);
        cs = 1'b1; wr = 1'b0; add = a;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b1 || data1 !== exp) begin
            n_fail++;
            $display("FAIL %s: rd_valid=%b data=%h, required rd_valid=1 data=%h", nm, rd_valid1, data1, exp);
        end
        cs = 1'b0;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: rd_valid=%b, required 0", nm, rd_valid1);
        end
    endtask

    task automatic write1(input logic [3:0] a, input logic [7:0] d, input logic inj);
        cs = 1'b1; wr = 1'b1; add = a; tb_dout = d; tb_den = 1'b1; inj_par = inj;
        tick();
        cs = 1'b0; wr = 1'b0; tb_den = 1'b0; inj_par = 1'b0;
    endtask

    task automatic wait_clear(input string nm);
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_checks++;
            if (ready1 !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_early: edge %0d ready=%b, required 0", nm, i, ready1);
            end
        end
        tick();
        n_checks++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: ready1=%b ready2=%b after 16 edges, required 1", nm, ready1, ready2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b0; cs2 = 1'b0; wr = 1'b0; add = 4'h0;
        inj_par = 1'b0; tb_dout = 8'h00; tb_den = 1'b0; tb_den2 = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({ready1, rd_valid1, err1, par_err1, ready2, rd_valid2} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_state: ready/rd_valid/err/par_err/ready2/rd_valid2=%b, required 000000",
                     {ready1, rd_valid1, err1, par_err1, ready2, rd_valid2});
        end
        rst = 1'b0;
        wait_clear("reset");
    endtask

    task automatic test_clear_reads();
        for (int i = 0; i < 16; i++) begin
            read1(4'(i), 8'h00, "clear_read");
        end
    endtask

    task automatic test_write_read();
        cs = 1'b1; wr = 1'b1; add = 4'h3; tb_dout = 8'hA5; tb_den = 1'b1;
        tick();
        tb_den = 1'b0; wr = 1'b0;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b1 || data1 !== 8'hA5) begin
            n_fail++;
            $display("FAIL raw_read: rd_valid=%b data=%h, required 1 a5", rd_valid1, data1);
        end
        cs = 1'b0;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_single_cycle: rd_valid=%b, required 0", rd_valid1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        cs = 1'b1; cs2 = 1'b1; wr = 1'b1; tb_den = 1'b1; tb_den2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            add = 4'(i);
            tb_dout = 8'(8'h10 + i);
            tick();
        end
        wr = 1'b0; tb_den = 1'b0; tb_den2 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            add = 4'(15 - k);
            tick();
            exp = 8'(8'h1F - k);
            n_checks++;
            if (rd_valid1 !== 1'b1 || data1 !== exp) begin
                n_fail++;
                $display("FAIL b2b_lat1: k=%0d rd_valid=%b data=%h, required 1 %h", k, rd_valid1, data1, exp);
            end
            n_checks++;
            if (k == 0) begin
                if (rd_valid2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_lat2_first: rd_valid2=%b one cycle after first read, required 0", rd_valid2);
                end
            end else begin
                exp = 8'(8'h1F - (k - 1));
                if (rd_valid2 !== 1'b1 || data2 !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_lat2: k=%0d rd_valid2=%b data2=%h, required 1 %h", k, rd_valid2, data2, exp);
                end
            end
        end
        cs = 1'b0; cs2 = 1'b0;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b1 || data2 !== 8'h10) begin
            n_fail++;
            $display("FAIL b2b_tail: rd_valid1=%b rd_valid2=%b data2=%h, required 0 1 10", rd_valid1, rd_valid2, data2);
        end
        tick();
        n_checks++;
        if (rd_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_lat2_end: rd_valid2=%b, required 0", rd_valid2);
        end
    endtask

    task automatic test_contention();
        cs = 1'b1; wr = 1'b0; add = 4'h5;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b1 || data1 !== 8'h15 || err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_read: rd_valid=%b data=%h err=%b, required 1 15 0", rd_valid1, data1, err1);
        end
        wr = 1'b1; tb_dout = 8'hFF; tb_den = 1'b1;
        tick();
        cs = 1'b0; wr = 1'b0; tb_den = 1'b0;
        n_checks++;
        if (err1 !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_err: err=%b, required 1", err1);
        end
        tick();
        tick();
        n_checks++;
        if (err1 !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_sticky: err=%b, required 1", err1);
        end
        read1(4'h5, 8'h15, "cont_old_value");
        n_checks++;
        if (err1 !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_sticky2: err=%b, required 1", err1);
        end
    endtask

    task automatic test_parity();
        write1(4'h7, 8'h3C, 1'b1);
        cs = 1'b1; wr = 1'b0; add = 4'h7;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b1 || data1 !== 8'h3C || par_err1 !== EXP_INJ_PERR) begin
            n_fail++;
            $display("FAIL par_inject: rd_valid=%b data=%h par_err=%b, required 1 3c %b",
                     rd_valid1, data1, par_err1, EXP_INJ_PERR);
        end
        cs = 1'b0;
        tick();
        write1(4'h7, 8'h3C, 1'b0);
        cs = 1'b1; wr = 1'b0; add = 4'h7;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b1 || par_err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL par_clean: rd_valid=%b par_err=%b, required 1 0", rd_valid1, par_err1);
        end
        cs = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_ops();
        cs = 1'b1; wr = 1'b0; add = 4'h7;
        tick();
        n_checks++;
        if (rd_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_valid: rd_valid=%b, required 1", rd_valid1);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rd_valid1 !== 1'b0 || err1 !== 1'b0 || ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_async: rd_valid=%b err=%b ready=%b, required 0 0 0", rd_valid1, err1, ready1);
        end
        cs = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear("midclear");
        read1(4'h3, 8'h00, "reclear_a3");
        read1(4'h7, 8'h00, "reclear_a7");
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_write_read();
        test_back_to_back();
        test_contention();
        test_parity();
        test_reset_mid_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_inout_param.md
Name: ram_inout_param

Overview:
- Parametrised single-port synchronous RAM with one bidirectional data bus; successor to the fixed 16x8 inout RAM.
- Adds configurable width, depth and read latency.
- Adds hardware memory clear after reset, a ready indication and a read-valid strobe.
- Detects bus contention, where a write arrives while the RAM is driving the bus.
- Sits between a bus master, which drives `data` only when writing, and on-chip storage.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles. Legal values are 1 and 2; any other value is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  chip select; a request is sampled only when cs=1.
- wr  input  1  1 = write request, 0 = read request (with cs=1).
- add  input  ADDR_W  word address.
- data  inout  DATA_W  bidirectional data; the RAM drives it only while drive_en=1, otherwise it is high-Z.
- ready  output  1  high once the memory clear has completed.
- rd_valid  output  1  high in each cycle the RAM drives valid read data.
- err  output  1  sticky contention flag.
- inj_par  input  1  parity-error injection; used only when RAM_PARITY_EN is defined.
- par_err  output  1  parity mismatch strobe; tied 0 when RAM_PARITY_EN is not defined.

Behaviour:
- Reset (async, during rst=1):
  - ready=0, rd_valid=0, err=0, par_err=0.
  - drive_en=0, so the bus is released immediately, not at the next edge.
  - State goes to INIT; clear pointer clr_ptr=0; the read pipeline is flushed.
  - Memory contents are not reset asynchronously.
- States: INIT, IDLE.
- INIT:
  - Each edge writes 0 to mem[clr_ptr], then clr_ptr increments.
  - The edge that writes DEPTH-1 moves the state to IDLE and sets ready=1. ready therefore rises on the DEPTH-th edge after rst deasserts.
  - cs/wr/add are ignored in INIT: no write, no read, no err.
- IDLE, write (cs=1, wr=1 at an edge, drive_en=0): mem[add] <= data.
- IDLE, read (cs=1, wr=0 at an edge):
  - mem[add] enters the read pipeline.
  - RD_LAT=1: drive_en=1 and rd_valid=1 for exactly the one cycle following the accepting edge.
  - RD_LAT=2: the same, one cycle later.
  - Back-to-back reads are accepted every cycle; drive_en/rd_valid then stay high continuously and data changes each cycle.
- Read-after-write to the same address on consecutive edges returns the newly written value.
- Contention (cs=1, wr=1 at an edge while drive_en=1):
  - The write is discarded.
  - err is set and stays 1 until rst.
  - The in-flight read still completes normally.
- cs=0: no access; the pipeline keeps draining.
- Address wrap does not apply: every add value is in range.
- Reset mid-read or mid-clear: the bus is released at once; after rst deasserts the clear restarts from address 0 and the full clear is repeated.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed on write.
  - If inj_par=1 during an accepted write, the stored parity bit is inverted.
  - INIT stores correct parity for the zero words.
  - On each read, parity is recomputed; par_err=1 in the same cycle as rd_valid if it mismatches, otherwise 0.
- Not defined:
  - There is no parity storage.
  - inj_par is ignored.
  - par_err is constant 0.

Decomposition:
- Shared package ram_pkg holds:
  - the state encoding constants ST_INIT and ST_IDLE;
  - the legal-RD_LAT check;
  - a parity function.
- One sub-module, ram_sp_core: the storage array plus optional parity bit. It has a synchronous write port and a registered read.
- The top level owns the FSM, clear pointer, latency pipeline, tri-state driver and err logic.

Test Plan (DATA_W=8, ADDR_W=4 unless noted):
- Reset then idle:
  - ready=0 for 15 edges and 1 after the 16th.
  - Reads of all 16 addresses return 8'h00.
  - data is high-Z whenever rd_valid=0.
- Write then read, RD_LAT=1:
  - Write add=3 data=8'hA5, then read add=3 on the next edge.
  - data=8'hA5 with rd_valid=1 for exactly one cycle, one cycle after the read edge.
- Back-to-back reads, repeated with RD_LAT=2:
  - Fill addresses 0..15 with 8'h10+i, then issue 16 consecutive reads, 15 down to 0.
  - data sequence is 8'h1F..8'h10 with rd_valid held high.
  - First data appears 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2) after the first read.
- Contention:
  - Read add=5, then assert a write of add=5 data=8'hFF on the edge where drive_en=1.
  - err=1 and stays 1.
  - A subsequent read of add=5 returns the old value.
- Reset mid-clear:
  - Assert rst 5 edges into INIT.
  - ready stays 0 until 16 edges after the second deassert.
- RAM_PARITY_EN:
  - Write add=7 data=8'h3C with inj_par=1, then read add=7: par_err=1 alongside rd_valid.
  - Rewrite with inj_par=0 and read again: par_err=0.
